ntt_bram_responder: RTL and testbench
=====================================

// Module: ntt_bram_responder
// PURPOSE
//  Responder (memory) end of the 64-bit NTT BRAM port-B interface driven by ntt_bram.
//  Holds DEPTH words of coefficient storage plus a two-word mailbox (CTRL doorbell,
//  STAT status) that a host-side agent (PS model or bench) services via a job handshake.
//  Closes the loop with ntt_bram in simulation and in PL-only builds without the PS block design.
// PARAMETERS
//  ADDR_W        13        BRAM_addr width
//  DATA_W        64        data word width
//  DEPTH         8192      storage words; addresses >= DEPTH-2 are mailbox
//  READ_LATENCY  1         en-to-dout cycles, legal 1..3
//  CTRL_ADDR     DEPTH-2   doorbell/job word address
//  STAT_ADDR     DEPTH-1   status word address (read-only from port)
// PORTS
//  clk          in   1       single clock for all logic
//  rstn         in   1       async active-low reset
//  BRAM_addr    in   ADDR_W  word address
//  BRAM_clk     in   1       must equal clk; used only by an equality assertion
//  BRAM_din     in   DATA_W  write data
//  BRAM_dout    out  DATA_W  read data
//  BRAM_en      in   1       access enable
//  BRAM_rst     in   1       sync output-register clear
//  BRAM_we      in   1       1=write, 0=read (qualified by en)
//  host_we      in   1       host preload write request
//  host_addr    in   ADDR_W  host preload address
//  host_wdata   in   DATA_W  host preload data
//  host_ready   out  1       host write accepted this cycle
//  job_valid    out  1       doorbell job pending for host
//  job_data     out  DATA_W  latched doorbell word
//  job_ready    in   1       host takes job
//  done_valid   in   1       host reports job complete (1-cycle pulse)
//  done_data    in   62      host result field
//  busy         out  1       job pending or in progress
// BEHAVIOUR
//  - Reset (rstn=0): BRAM_dout=0, read pipe cleared, FSM=MB_IDLE, job_valid=0, job_data=0,
//    busy=0, STAT=0, overrun=0. Storage array is not reset.
//  - Read: en=1,we=0 at edge t -> BRAM_dout valid after edge t+READ_LATENCY; held until next read result.
//  - Write: en=1,we=1 commits din at edge; dout unchanged. Read next cycle returns new data.
//  - BRAM_rst=1 && en=1: clears final dout register to 0 at edge; memory and FSM untouched.
//  - Address decode: addr<DEPTH-2 storage; CTRL read returns job_data; STAT read returns
//    {result[61:0], overrun, busy}; STAT writes ignored; addr>=DEPTH reads 0, writes dropped.
//  - Host preload: host_ready = !(BRAM_en && BRAM_we). Commit when host_we && host_ready.
//    Port write always wins; host retries. Host writes to CTRL/STAT/out-of-range dropped.
//    Same-cycle port read of host-written address returns old data.
//  - Mailbox FSM (mb_state_t):
//    MB_IDLE: port write to CTRL -> latch job_data=din, -> MB_PEND.
//    MB_PEND: job_valid=1; job_valid && job_ready -> MB_BUSY.
//    MB_BUSY: done_valid -> result<=done_data, -> MB_IDLE.
//    busy=1 in MB_PEND and MB_BUSY. done_valid outside MB_BUSY ignored.
//  - CTRL write while not MB_IDLE: dropped (job_data unchanged), overrun set sticky until rstn.
//  - CTRL write in the same cycle as the done_valid that returns FSM to IDLE: dropped + overrun
//    (doorbell sampled against current state).
//  - rstn asserted mid-job: immediate return to IDLE; pending job lost; result cleared.
// STRUCTURE
//  - Package ntt_bram_pkg: ADDR_W, DATA_W, CTRL/STAT offsets, mb_state_t {MB_IDLE,MB_PEND,MB_BUSY},
//    STAT bit positions.
//  - Sub-module ntt_bram_rdpipe: READ_LATENCY-deep data delay line with sync clear
//    (BRAM_rst) and async reset. Storage, decode and FSM live in the top.
// TESTING
//  - Reset: rstn low mid-traffic -> dout=0, busy=0, job_valid=0, STAT read = 0.
//  - Write 0x1234_5678_9ABC_DEF0 @0x0010, read @0x0010 -> dout matches after READ_LATENCY (1 and 3).
//  - Host preload collides with port write same cycle -> host_ready=0, port data kept; host retry succeeds.
//  - Doorbell: write 0xA5 to CTRL -> job_valid=1, job_data=0xA5; ready -> busy=1;
//    done_data=0x3 -> STAT reads 0xC.
//  - Second CTRL write while busy -> dropped, STAT bit1=1, job_data stays 0xA5.
//  - BRAM_rst with en after a read -> dout=0 next cycle; re-read returns stored value.

Source files
------------

// File: rtl/ntt_bram_pkg.sv
// Shared definitions for the NTT BRAM port-B responder.
// Holds the default geometry, the mailbox offsets, the mailbox state
// encoding and the STAT word layout, plus a helper that packs the STAT word.
package ntt_bram_pkg;

  localparam int ADDR_W   = 13;
  localparam int DATA_W   = 64;
  localparam int DEPTH    = 8192;

  // Mailbox words sit at the top of the address space, below DEPTH.
  localparam int CTRL_OFS = 2;
  localparam int STAT_OFS = 1;

  // STAT word layout: {result[61:0], overrun, busy}
  localparam int RESULT_W      = 62;
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_OVR_BIT  = 1;
  localparam int STAT_RES_LSB  = 2;

  typedef enum logic [1:0] {
    MB_IDLE = 2'd0,
    MB_PEND = 2'd1,
    MB_BUSY = 2'd2
  } mb_state_t;

  // Pack the status word returned on a STAT read.
  function automatic logic [DATA_W-1:0] stat_word(
    input logic [RESULT_W-1:0] result,
    input logic                overrun,
    input logic                busy
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[STAT_BUSY_BIT] = busy;
    w[STAT_OVR_BIT]  = overrun;
    w[STAT_RES_LSB +: RESULT_W] = result;
    return w;
  endfunction

endpackage

// File: rtl/ntt_bram_rdpipe.sv
// Read-data delay line for the responder.
// LAT register stages; the last stage is the visible output register, which
// only loads when a valid read result reaches it, so it holds the previous
// result between reads. clr zeroes only that output register.
// Ports:
//   clk, rstn  clock and async active-low reset (whole pipe cleared)
//   clr        synchronous clear of the output register
//   in_vld     a read result is present on in_data
//   in_data    read result entering the pipe
//   out_data   held read data (BRAM_dout)
module ntt_bram_rdpipe #(
  parameter int DATA_W = 64,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data
);

  logic              tail_vld_s;
  logic [DATA_W-1:0] tail_data_s;
  logic [DATA_W-1:0] out_r;

  if (LAT <= 1) begin : g_direct
    assign tail_vld_s  = in_vld;
    assign tail_data_s = in_data;
  end else begin : g_stages
    logic [LAT-2:0]    vld_r;
    logic [DATA_W-1:0] dat_r [0:LAT-2];

    // Intermediate delay stages ahead of the output register.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        vld_r <= '0;
        for (int i = 0; i < LAT-1; i++) begin
          dat_r[i] <= '0;
        end
      end else begin
        vld_r[0] <= in_vld;
        dat_r[0] <= in_data;
        for (int i = 1; i < LAT-1; i++) begin
          vld_r[i] <= vld_r[i-1];
          dat_r[i] <= dat_r[i-1];
        end
      end
    end

    assign tail_vld_s  = vld_r[LAT-2];
    assign tail_data_s = dat_r[LAT-2];
  end

  // Output register: cleared by clr, otherwise holds until the next result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_r <= '0;
    end else if (clr) begin
      out_r <= '0;
    end else if (tail_vld_s) begin
      out_r <= tail_data_s;
    end
  end

  assign out_data = out_r;

endmodule

// File: rtl/ntt_bram_responder_chk.sv
// Property checker bound into the responder: the BRAM port clock must be the
// same net as the core clock.
// Ports: clk, rstn, BRAM_clk (all observed only).
module ntt_bram_responder_chk (
  input logic clk,
  input logic rstn,
  input logic BRAM_clk
);

  a_bram_clk_eq: assert property (@(posedge clk) disable iff (!rstn) (BRAM_clk == clk));

endmodule

// File: rtl/ntt_bram_responder.sv
// Memory end of the 64-bit NTT BRAM port-B interface.
// Storage words below CTRL_ADDR, a CTRL doorbell word and a read-only STAT
// word. A doorbell write raises a job toward a host agent, which takes it
// (job_ready) and later reports completion (done_valid/done_data).
// Ports:
//   clk, rstn                     clock, async active-low reset
//   BRAM_addr/din/dout/en/we/rst  port-B access (rst clears dout register)
//   BRAM_clk                      must equal clk; checked only
//   host_we/addr/wdata/ready      host preload path, port writes take priority
//   job_valid/job_data/job_ready  doorbell job handoff to the host
//   done_valid/done_data          host completion report
//   busy                          job pending or in progress
module ntt_bram_responder #(
  parameter int ADDR_W       = ntt_bram_pkg::ADDR_W,
  parameter int DATA_W       = ntt_bram_pkg::DATA_W,
  parameter int DEPTH        = ntt_bram_pkg::DEPTH,
  parameter int READ_LATENCY = 1,
  parameter int CTRL_ADDR    = DEPTH - ntt_bram_pkg::CTRL_OFS,
  parameter int STAT_ADDR    = DEPTH - ntt_bram_pkg::STAT_OFS
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [ADDR_W-1:0]                 BRAM_addr,
  input  logic                              BRAM_clk,
  input  logic [DATA_W-1:0]                 BRAM_din,
  output logic [DATA_W-1:0]                 BRAM_dout,
  input  logic                              BRAM_en,
  input  logic                              BRAM_rst,
  input  logic                              BRAM_we,
  input  logic                              host_we,
  input  logic [ADDR_W-1:0]                 host_addr,
  input  logic [DATA_W-1:0]                 host_wdata,
  output logic                              host_ready,
  output logic                              job_valid,
  output logic [DATA_W-1:0]                 job_data,
  input  logic                              job_ready,
  input  logic                              done_valid,
  input  logic [ntt_bram_pkg::RESULT_W-1:0] done_data,
  output logic                              busy
);

  import ntt_bram_pkg::*;

  localparam int STORE_WORDS = CTRL_ADDR;

  logic [DATA_W-1:0]   mem_r [0:STORE_WORDS-1];

  mb_state_t           mb_state_r;
  logic                job_valid_r;
  logic                busy_r;
  logic                overrun_r;
  logic [DATA_W-1:0]   job_data_r;
  logic [RESULT_W-1:0] result_r;

  logic                rd_vld_r;
  logic [DATA_W-1:0]   rd_dat_r;

  logic [31:0]         port_addr_s;
  logic [31:0]         host_addr_s;
  logic                port_store_s;
  logic                port_ctrl_s;
  logic                port_stat_s;
  logic                host_store_s;
  logic                port_wr_s;
  logic                port_rd_s;
  logic                ctrl_wr_s;
  logic                wr_en_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [DATA_W-1:0]   wr_data_s;
  logic [DATA_W-1:0]   rd_word_s;

  // Address decode; widened so out-of-range addresses compare correctly.
  assign port_addr_s  = 32'(BRAM_addr);
  assign host_addr_s  = 32'(host_addr);
  assign port_store_s = (port_addr_s < 32'(STORE_WORDS));
  assign port_ctrl_s  = (port_addr_s == 32'(CTRL_ADDR));
  assign port_stat_s  = (port_addr_s == 32'(STAT_ADDR));
  assign host_store_s = (host_addr_s < 32'(STORE_WORDS));

  assign port_wr_s  = BRAM_en && BRAM_we;
  // A BRAM_rst cycle only clears the output; it does not start a read.
  assign port_rd_s  = BRAM_en && !BRAM_we && !BRAM_rst;
  assign ctrl_wr_s  = port_wr_s && port_ctrl_s;
  assign host_ready = !port_wr_s;

  // Single storage write port: port write wins, host write fills idle cycles.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = BRAM_addr;
    wr_data_s = BRAM_din;
    if (port_wr_s) begin
      wr_en_s = port_store_s;
    end else if (host_we) begin
      wr_en_s   = host_store_s;
      wr_addr_s = host_addr;
      wr_data_s = host_wdata;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Coefficient storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Read source select; mailbox words return their current register values.
  always_comb begin
    rd_word_s = '0;
    if (port_store_s) begin
      rd_word_s = mem_r[BRAM_addr];
    end else if (port_ctrl_s) begin
      rd_word_s = job_data_r;
    end else if (port_stat_s) begin
      rd_word_s = stat_word(result_r, overrun_r, busy_r);
    end else begin
      rd_word_s = '0;
    end
  end

  // First read stage: captures the addressed word at the issuing edge, so a
  // host write landing on the same edge is not yet visible.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_r <= 1'b0;
      rd_dat_r <= '0;
    end else begin
      rd_vld_r <= port_rd_s;
      if (port_rd_s) begin
        rd_dat_r <= rd_word_s;
      end
    end
  end

  ntt_bram_rdpipe #(
    .DATA_W (DATA_W),
    .LAT    (READ_LATENCY)
  ) u_rdpipe (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (BRAM_rst && BRAM_en),
    .in_vld   (rd_vld_r),
    .in_data  (rd_dat_r),
    .out_data (BRAM_dout)
  );

  // Mailbox FSM. A doorbell is judged against the current state, so one that
  // coincides with the completing done_valid is still an overrun.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mb_state_r  <= MB_IDLE;
      job_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      job_data_r  <= '0;
      result_r    <= '0;
    end else begin
      case (mb_state_r)
        MB_IDLE: begin
          if (ctrl_wr_s) begin
            job_data_r  <= BRAM_din;
            job_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            mb_state_r  <= MB_PEND;
          end
        end
        MB_PEND: begin
          if (ctrl_wr_s) begin
            overrun_r <= 1'b1;
          end
          if (job_valid_r && job_ready) begin
            job_valid_r <= 1'b0;
            mb_state_r  <= MB_BUSY;
          end
        end
        MB_BUSY: begin
          if (ctrl_wr_s) begin
            overrun_r <= 1'b1;
          end
          if (done_valid) begin
            result_r   <= done_data;
            busy_r     <= 1'b0;
            mb_state_r <= MB_IDLE;
          end
        end
        default: begin
          job_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          mb_state_r  <= MB_IDLE;
        end
      endcase
    end
  end

  assign job_valid = job_valid_r;
  assign job_data  = job_data_r;
  assign busy      = busy_r;

  ntt_bram_responder_chk u_chk (
    .clk      (clk),
    .rstn     (rstn),
    .BRAM_clk (BRAM_clk)
  );

endmodule

// File: tb/tb_ntt_bram_responder.sv
// Bench for ntt_bram_responder: two instances (read latency 1 and 3) share
// all stimulus. Read results are checked through per-instance expectation
// queues filled when a read is issued and drained when its data is due.
module tb_ntt_bram_responder;

  localparam logic [12:0] CTRL_A = 13'd8190;
  localparam logic [12:0] STAT_A = 13'd8191;

  logic        clk = 1'b0;
  logic        bram_clk = 1'b0;
  logic        rstn;
  logic [12:0] addr;
  logic [63:0] din;
  logic        en, brst, we;
  logic        host_we;
  logic [12:0] host_addr;
  logic [63:0] host_wdata;
  logic        job_ready, done_valid;
  logic [61:0] done_data;

  logic [63:0] dout1, dout3, job_data1, job_data3;
  logic        host_ready1, host_ready3, job_valid1, job_valid3, busy1, busy3;

  int          total = 0;
  int          bad = 0;
  logic [63:0] q1[$];
  logic [63:0] q3[$];
  logic [3:0]  hist = 4'd0;
  logic [63:0] e1, e3;

  always #5 begin
    clk      = ~clk;
    bram_clk = ~bram_clk;
  end

  ntt_bram_responder #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn), .BRAM_addr(addr), .BRAM_clk(bram_clk), .BRAM_din(din),
    .BRAM_dout(dout1), .BRAM_en(en), .BRAM_rst(brst), .BRAM_we(we),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready1),
    .job_valid(job_valid1), .job_data(job_data1), .job_ready(job_ready),
    .done_valid(done_valid), .done_data(done_data), .busy(busy1)
  );

  ntt_bram_responder #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .rstn(rstn), .BRAM_addr(addr), .BRAM_clk(bram_clk), .BRAM_din(din),
    .BRAM_dout(dout3), .BRAM_en(en), .BRAM_rst(brst), .BRAM_we(we),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready3),
    .job_valid(job_valid3), .job_data(job_data3), .job_ready(job_ready),
    .done_valid(done_valid), .done_data(done_data), .busy(busy3)
  );

  // Read monitor: record issued reads at each edge, compare dout once due.
  always @(posedge clk) begin
    hist = {hist[2:0], (rstn && en && !we && !brst)};
    #1;
    if (hist[1]) begin
      total++;
      if (q1.size() == 0) begin
        bad++;
        $display("FAIL rd_lat1 got=%h required=nothing_queued", dout1);
      end else begin
        e1 = q1.pop_front();
        if (dout1 !== e1) begin
          bad++;
          $display("FAIL rd_lat1 got=%h required=%h", dout1, e1);
        end
      end
    end
    if (hist[3]) begin
      total++;
      if (q3.size() == 0) begin
        bad++;
        $display("FAIL rd_lat3 got=%h required=nothing_queued", dout3);
      end else begin
        e3 = q3.pop_front();
        if (dout3 !== e3) begin
          bad++;
          $display("FAIL rd_lat3 got=%h required=%h", dout3, e3);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic port_write(input logic [12:0] a, input logic [63:0] d);
    en = 1'b1; we = 1'b1; addr = a; din = d;
    tick();
    en = 1'b0; we = 1'b0;
  endtask

  task automatic port_read(input logic [12:0] a, input logic [63:0] exp);
    en = 1'b1; we = 1'b0; addr = a;
    q1.push_back(exp);
    q3.push_back(exp);
    tick();
    en = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (q1.size() != 0 || q3.size() != 0) tick();
    end
    tick();
    total++;
    if (q1.size() != 0 || q3.size() != 0) begin
      bad++;
      $display("FAIL drain pending lat1=%0d lat3=%0d required=0", q1.size(), q3.size());
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    en = 1'b0; we = 1'b0; brst = 1'b0; addr = 13'd0; din = 64'd0;
    host_we = 1'b0; host_addr = 13'd0; host_wdata = 64'd0;
    job_ready = 1'b0; done_valid = 1'b0; done_data = 62'd0;
    tick();
    tick();
    total++;
    if (dout1 !== 64'd0 || dout3 !== 64'd0) begin
      bad++;
      $display("FAIL reset_dout got=%h/%h required=0", dout1, dout3);
    end
    total++;
    if (busy1 !== 1'b0 || job_valid1 !== 1'b0 || job_data1 !== 64'd0) begin
      bad++;
      $display("FAIL reset_mbox got busy=%b jv=%b jd=%h required=0/0/0", busy1, job_valid1, job_data1);
    end
    rstn = 1'b1;
    tick();
    port_read(STAT_A, 64'd0);
    drain();
  endtask

  task automatic test_rw();
    port_write(13'h0010, 64'h1234_5678_9ABC_DEF0);
    port_read(13'h0010, 64'h1234_5678_9ABC_DEF0);
    port_write(13'h0011, 64'hAAAA_0000_5555_FFFF);
    port_write(13'h1FFD, 64'hFEED_FACE_CAFE_BEEF);
    port_read(13'h0011, 64'hAAAA_0000_5555_FFFF);
    port_read(13'h1FFD, 64'hFEED_FACE_CAFE_BEEF);
    port_read(13'h0010, 64'h1234_5678_9ABC_DEF0);
    drain();
    // Output holds the last result while no read is issued.
    total++;
    if (dout1 !== 64'h1234_5678_9ABC_DEF0 || dout3 !== 64'h1234_5678_9ABC_DEF0) begin
      bad++;
      $display("FAIL rd_hold got=%h/%h required=123456789abcdef0", dout1, dout3);
    end
  endtask

  task automatic test_host();
    // Collision: port write and host write in the same cycle.
    en = 1'b1; we = 1'b1; addr = 13'h0020; din = 64'h0000_0000_0000_0111;
    host_we = 1'b1; host_addr = 13'h0020; host_wdata = 64'h0000_0000_0000_0222;
    #1;
    total++;
    if (host_ready1 !== 1'b0 || host_ready3 !== 1'b0) begin
      bad++;
      $display("FAIL host_collide_ready got=%b/%b required=0", host_ready1, host_ready3);
    end
    tick();
    // Host retries while the port reads the same word: read sees old data.
    we = 1'b0; en = 1'b1; addr = 13'h0020;
    q1.push_back(64'h0000_0000_0000_0111);
    q3.push_back(64'h0000_0000_0000_0111);
    #1;
    total++;
    if (host_ready1 !== 1'b1) begin
      bad++;
      $display("FAIL host_retry_ready got=%b required=1", host_ready1);
    end
    tick();
    en = 1'b0;
    host_addr = CTRL_A; host_wdata = 64'hDEAD;
    tick();
    host_we = 1'b0;
    port_read(13'h0020, 64'h0000_0000_0000_0222);
    port_read(CTRL_A, 64'd0);
    drain();
  endtask

  task automatic test_doorbell();
    port_write(CTRL_A, 64'hA5);
    total++;
    if (job_valid1 !== 1'b1 || job_data1 !== 64'hA5 || busy1 !== 1'b1) begin
      bad++;
      $display("FAIL db_pend got jv=%b jd=%h busy=%b required=1/a5/1", job_valid1, job_data1, busy1);
    end
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
    total++;
    if (job_valid1 !== 1'b0 || busy1 !== 1'b1 || busy3 !== 1'b1) begin
      bad++;
      $display("FAIL db_busy got jv=%b busy=%b required=0/1", job_valid1, busy1);
    end
    // Doorbell while busy is dropped and flags overrun.
    port_write(CTRL_A, 64'h77);
    total++;
    if (job_data1 !== 64'hA5) begin
      bad++;
      $display("FAIL db_overrun_data got=%h required=a5", job_data1);
    end
    port_read(STAT_A, 64'h3);
    done_valid = 1'b1; done_data = 62'd3;
    tick();
    done_valid = 1'b0;
    total++;
    if (busy1 !== 1'b0) begin
      bad++;
      $display("FAIL db_done_busy got=%b required=0", busy1);
    end
    port_read(STAT_A, 64'hE);
    port_read(CTRL_A, 64'hA5);
    // done_valid while idle is ignored.
    done_valid = 1'b1; done_data = 62'd5;
    tick();
    done_valid = 1'b0;
    port_read(STAT_A, 64'hE);
    drain();
  endtask

  task automatic test_doorbell_vs_done();
    port_write(CTRL_A, 64'h5A);
    total++;
    if (job_valid1 !== 1'b1 || job_data1 !== 64'h5A) begin
      bad++;
      $display("FAIL db2_pend got jv=%b jd=%h required=1/5a", job_valid1, job_data1);
    end
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
    // Doorbell on the same edge as the completing done_valid.
    en = 1'b1; we = 1'b1; addr = CTRL_A; din = 64'h99;
    done_valid = 1'b1; done_data = 62'd7;
    tick();
    en = 1'b0; we = 1'b0; done_valid = 1'b0;
    total++;
    if (job_data1 !== 64'h5A || busy1 !== 1'b0 || job_valid1 !== 1'b0) begin
      bad++;
      $display("FAIL db2_same_cycle got jd=%h busy=%b jv=%b required=5a/0/0", job_data1, busy1, job_valid1);
    end
    port_read(STAT_A, 64'h1E);
    drain();
  endtask

  task automatic test_bram_rst();
    port_write(13'h0040, 64'h0BAD_F00D_1357_2468);
    port_read(13'h0040, 64'h0BAD_F00D_1357_2468);
    drain();
    en = 1'b1; we = 1'b0; brst = 1'b1; addr = 13'h0040;
    tick();
    en = 1'b0; brst = 1'b0;
    total++;
    if (dout1 !== 64'd0 || dout3 !== 64'd0) begin
      bad++;
      $display("FAIL bram_rst_clear got=%h/%h required=0", dout1, dout3);
    end
    port_read(13'h0040, 64'h0BAD_F00D_1357_2468);
    drain();
  endtask

  task automatic test_reset_mid_job();
    port_write(CTRL_A, 64'h33);
    en = 1'b1; we = 1'b0; addr = 13'h0010;
    tick();
    en = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    total++;
    if (dout1 !== 64'd0 || dout3 !== 64'd0 || busy1 !== 1'b0 || job_valid1 !== 1'b0 || job_data1 !== 64'd0) begin
      bad++;
      $display("FAIL reset_mid got dout=%h/%h busy=%b jv=%b jd=%h required=0", dout1, dout3, busy1, job_valid1, job_data1);
    end
    // In-flight read and pending job are discarded by reset.
    q1.delete();
    q3.delete();
    hist = 4'd0;
    tick();
    tick();
    rstn = 1'b1;
    tick();
    port_read(STAT_A, 64'd0);
    port_read(13'h0010, 64'h1234_5678_9ABC_DEF0);
    drain();
  endtask

  initial begin
    test_reset();
    test_rw();
    test_host();
    test_doorbell();
    test_doorbell_vs_done();
    test_bram_rst();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
